// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame constants and sample-point helpers
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Counter value at which the start bit is checked: half a bit after the falling edge.
    function automatic int start_sample_pt(input int clk_per_bit);
        return clk_per_bit / 2 - 1;
    endfunction

    // Once the start bit has been confirmed mid-bit, the counter restarts there, so every
    // later bit centre is reached one full bit period later.
    function automatic int frame_sample_pt(input int clk_per_bit);
        return clk_per_bit - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - two-flop synchroniser followed by a 3-tap majority vote
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic vote
);

    logic [1:0] sync_q;
    logic [2:0] tap_q;

    // Synchronise the raw pin and keep the last three synchronised samples; idle-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            tap_q  <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], din};
            tap_q  <= {tap_q[1:0], sync_q[1]};
        end
    end

    // Any single-clock disturbance is outvoted by its two neighbours.
    assign vote = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);

endmodule

// File: rtl/uart_rx_filt.sv
// rtl/uart_rx_filt.sv - noise-tolerant 8N1 UART receiver, even parity bit added when UART_RX_PARITY_EN is defined
module uart_rx_filt
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial_line,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam int                CNT_W    = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0]  START_PT = CNT_W'(start_sample_pt(CLK_PER_BIT));
    localparam logic [CNT_W-1:0]  FRAME_PT = CNT_W'(frame_sample_pt(CLK_PER_BIT));
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d, cnt_inc;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           rx_data_d;
    logic                 rx_ready_d;
    logic                 frame_err_d;
    logic                 parity_ok;
    logic                 vote;

    uart_rx_sampler u_sampler (
        .clk  (clk),
        .rst  (rst),
        .din  (rx_serial_line),
        .vote (vote)
    );

    // clk_cnt wraps after CLK_PER_BIT clocks even when that is not a power of two.
    assign cnt_inc = (clk_cnt_q == FRAME_PT) ? '0 : clk_cnt_q + 1'b1;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;

    // Even parity: data bits plus parity bit carry an even number of ones.
    assign parity_ok = (par_q == ^shreg_q);
`else
    assign parity_ok = 1'b1;
`endif

    // Next-state, counter, shift-register and output-strobe decisions.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = cnt_inc;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data;
        rx_ready_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!vote) begin
                    state_d = START;
                end
            end
            START: begin
                if (clk_cnt_q == START_PT) begin
                    clk_cnt_d = '0;
                    if (vote) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (clk_cnt_q == FRAME_PT) begin
                    shreg_d[bit_idx_q] = vote;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == FRAME_PT) begin
                    par_d   = vote;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == FRAME_PT) begin
                    clk_cnt_d = '0;
                    if (vote && parity_ok) begin
                        rx_data_d  = shreg_q;
                        rx_ready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // clk_cnt doubles as the run length of consecutive high votes.
                if (!vote) begin
                    clk_cnt_d = '0;
                end else if (clk_cnt_q == FRAME_PT) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // State register and all receiver datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            rx_data   <= 8'h00;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            rx_data   <= rx_data_d;
            rx_ready  <= rx_ready_d;
            frame_err <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
